// File: rtl/fir_coeff_pkg.sv
// Shared definitions for the fir_coeff register bridge: register offsets,
// STATUS bit positions and the handshake FSM state type.
package fir_coeff_pkg;

    localparam logic [3:0] ADR_STAGE0 = 4'h0;
    localparam logic [3:0] ADR_RDBK0  = 4'h4;
    localparam logic [3:0] ADR_CTRL   = 4'h8;
    localparam logic [3:0] ADR_STATUS = 4'h9;
    localparam logic [3:0] ADR_ID     = 4'hF;

    localparam int unsigned ST_BUSY = 0;
    localparam int unsigned ST_DONE = 1;
    localparam int unsigned ST_ERR  = 2;
    localparam int unsigned ST_TMO  = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_REL  = 2'd2
    } state_e;

endpackage

// File: rtl/fir_coeff_reg_bridge.sv
// Register-bus front end for fir_coeff_master: stages four write words,
// launches read/write ops over req/wr_op/ack and holds the read-back.
// Optional ack timeout enabled by defining FIR_COEFF_TIMEOUT_EN.
module fir_coeff_reg_bridge
    import fir_coeff_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [15:0] BRIDGE_ID      = 16'hF1C0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         bus_wr,
    input  logic         bus_rd,
    input  logic [3:0]   bus_adr,
    input  logic [31:0]  bus_wr_data,
    output logic [31:0]  bus_rd_data,
    output logic         bus_rd_valid,
    output logic         req,
    output logic         wr_op,
    input  logic         ack,
    output logic [127:0] coeff_wr_data,
    input  logic [127:0] coeff_rd_data,
    output logic         busy
);

    state_e         state_q, state_d;
    logic           wr_op_q, wr_op_d;
    logic [127:0]   stage_q, stage_d;
    logic [127:0]   rdbk_q, rdbk_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic [31:0]    rd_data_q, rd_data_d;
    logic           rd_valid_q, rd_valid_d;
    logic           tmo_bit;
    logic [1:0]     start_bits;
    logic           start;
    logic [31:0]    status_w;

`ifdef FIR_COEFF_TIMEOUT_EN
    logic           tmo_q, tmo_d;
    logic           op_tmo_q, op_tmo_d;
    logic [31:0]    cnt_q, cnt_d;
    assign tmo_bit = tmo_q;
`else
    logic [31:0]    unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES;
    assign tmo_bit = 1'b0;
`endif

    assign req           = (state_q == S_REQ);
    assign busy          = (state_q != S_IDLE);
    assign wr_op         = wr_op_q;
    assign coeff_wr_data = stage_q;
    assign bus_rd_data   = rd_data_q;
    assign bus_rd_valid  = rd_valid_q;
    assign start_bits    = bus_wr_data[1:0];

    // Register writes, STATUS W1C and the req/ack handshake FSM.
    // FSM status updates come after W1C so a same-cycle set is not lost.
    always_comb begin
        state_d = state_q;
        wr_op_d = wr_op_q;
        stage_d = stage_q;
        rdbk_d  = rdbk_q;
        done_d  = done_q;
        err_d   = err_q;
        start   = 1'b0;
`ifdef FIR_COEFF_TIMEOUT_EN
        tmo_d    = tmo_q;
        op_tmo_d = op_tmo_q;
        cnt_d    = '0;
`endif
        if (bus_wr) begin
            if (bus_adr[3:2] == ADR_STAGE0[3:2]) begin
                if (state_q != S_IDLE) err_d = 1'b1;
                else stage_d[{bus_adr[1:0], 5'b0} +: 32] = bus_wr_data;
            end
            if (bus_adr == ADR_CTRL && start_bits != 2'b00) begin
                if (state_q != S_IDLE || start_bits == 2'b11) err_d = 1'b1;
                else start = 1'b1;
            end
            if (bus_adr == ADR_STATUS) begin
                if (bus_wr_data[ST_DONE]) done_d = 1'b0;
                if (bus_wr_data[ST_ERR])  err_d  = 1'b0;
`ifdef FIR_COEFF_TIMEOUT_EN
                if (bus_wr_data[ST_TMO])  tmo_d  = 1'b0;
`endif
            end
        end
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    wr_op_d = start_bits[0];
                    done_d  = 1'b0;
                    state_d = S_REQ;
`ifdef FIR_COEFF_TIMEOUT_EN
                    op_tmo_d = 1'b0;
`endif
                end
            end
            S_REQ: begin
                if (ack) begin
                    if (!wr_op_q) rdbk_d = coeff_rd_data;
                    state_d = S_REL;
`ifdef FIR_COEFF_TIMEOUT_EN
                end else if (cnt_q == TIMEOUT_CYCLES - 1) begin
                    tmo_d    = 1'b1;
                    op_tmo_d = 1'b1;
                    state_d  = S_REL;
                end else begin
                    cnt_d = cnt_q + 32'd1;
`endif
                end
            end
            S_REL: begin
                if (!ack) begin
`ifdef FIR_COEFF_TIMEOUT_EN
                    if (!op_tmo_q) done_d = 1'b1;
`else
                    done_d = 1'b1;
`endif
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Read mux; registered so data and valid appear one cycle after bus_rd
    // and always reflect pre-write register contents.
    always_comb begin
        status_w          = '0;
        status_w[ST_BUSY] = busy;
        status_w[ST_DONE] = done_q;
        status_w[ST_ERR]  = err_q;
        status_w[ST_TMO]  = tmo_bit;
        rd_valid_d        = bus_rd;
        rd_data_d         = '0;
        if (bus_rd) begin
            if (bus_adr[3:2] == ADR_STAGE0[3:2])
                rd_data_d = stage_q[{bus_adr[1:0], 5'b0} +: 32];
            else if (bus_adr[3:2] == ADR_RDBK0[3:2])
                rd_data_d = rdbk_q[{bus_adr[1:0], 5'b0} +: 32];
            else if (bus_adr == ADR_STATUS)
                rd_data_d = status_w;
            else if (bus_adr == ADR_ID)
                rd_data_d = {16'h0000, BRIDGE_ID};
        end
    end

    // State and register storage with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            wr_op_q    <= 1'b0;
            stage_q    <= '0;
            rdbk_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
`ifdef FIR_COEFF_TIMEOUT_EN
            tmo_q      <= 1'b0;
            op_tmo_q   <= 1'b0;
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wr_op_q    <= wr_op_d;
            stage_q    <= stage_d;
            rdbk_q     <= rdbk_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
`ifdef FIR_COEFF_TIMEOUT_EN
            tmo_q      <= tmo_d;
            op_tmo_q   <= op_tmo_d;
            cnt_q      <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_fir_coeff_reg_bridge.sv
// Self-checking bench for fir_coeff_reg_bridge with a bus driver,
// a behavioural fir_coeff_master and a register-level reference model.
module tb_fir_coeff_reg_bridge;
    import fir_coeff_pkg::*;

`ifdef FIR_COEFF_TIMEOUT_EN
    localparam int unsigned TB_TMO = 16;
`else
    localparam int unsigned TB_TMO = 1024;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         bus_wr = 1'b0;
    logic         bus_rd = 1'b0;
    logic [3:0]   bus_adr = '0;
    logic [31:0]  bus_wr_data = '0;
    logic [31:0]  bus_rd_data;
    logic         bus_rd_valid;
    logic         req;
    logic         wr_op;
    logic         ack = 1'b0;
    logic [127:0] coeff_wr_data;
    logic [127:0] coeff_rd_data = '0;
    logic         busy;

    fir_coeff_reg_bridge #(.TIMEOUT_CYCLES(TB_TMO), .BRIDGE_ID(16'hF1C0)) dut (
        .clk(clk), .reset_n(reset_n), .bus_wr(bus_wr), .bus_rd(bus_rd),
        .bus_adr(bus_adr), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data),
        .bus_rd_valid(bus_rd_valid), .req(req), .wr_op(wr_op), .ack(ack),
        .coeff_wr_data(coeff_wr_data), .coeff_rd_data(coeff_rd_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Master model state
    logic         mst_en = 1'b1;
    int           rel_hold = 0;
    logic [127:0] mst_mem = '0;
    int           req_rises = 0;
    int           wr_op_glitch = 0;
    logic         last_wr_op = 1'b0;
    logic [127:0] last_wdata = '0;
    logic         req_prev = 1'b0;
    int           dly = 0;
    int           hold = 0;

    // Reference model of the register file
    logic [31:0]  stage_m [4];
    logic [127:0] rdbk_m;
    logic         done_m, err_m, tmo_m;

    always @(negedge clk) begin
        if (!reset_n) begin
            ack = 1'b0;
            req_prev = 1'b0;
        end else begin
            if (req && !req_prev) begin
                req_rises++;
                last_wr_op = wr_op;
                last_wdata = coeff_wr_data;
                dly = $urandom_range(0, 3);
            end
            if (req && wr_op !== last_wr_op) wr_op_glitch++;
            if (req && !ack && mst_en) begin
                if (dly == 0) begin
                    ack = 1'b1;
                    coeff_rd_data = mst_mem;
                    hold = rel_hold;
                end else dly--;
            end else if (ack && !req) begin
                if (hold == 0) ack = 1'b0;
                else hold--;
            end
            req_prev = req;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] stage_vec();
        return {stage_m[3], stage_m[2], stage_m[1], stage_m[0]};
    endfunction

    function automatic logic [31:0] status_exp(input logic b);
        return {28'd0, tmo_m, err_m, done_m, b};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) stage_m[i] = '0;
        rdbk_m = '0; done_m = 1'b0; err_m = 1'b0; tmo_m = 1'b0;
    endtask

    task automatic bus_write(input logic [3:0] adr, input logic [31:0] d);
        bus_adr = adr; bus_wr_data = d; bus_wr = 1'b1;
        @(negedge clk);
        bus_wr = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] adr, input logic [31:0] exp, input string tag);
        bus_adr = adr; bus_rd = 1'b1;
        @(negedge clk);
        bus_rd = 1'b0;
        chk({tag, " valid"}, bus_rd_valid, 1'b1);
        chk(tag, bus_rd_data, exp);
        @(negedge clk);
        chk({tag, " pulse"}, bus_rd_valid, 1'b0);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " idle"}, busy, 1'b0);
    endtask

    task automatic run_op(input logic rd, input string tag);
        int r0;
        r0 = req_rises;
        bus_write(ADR_CTRL, rd ? 32'd2 : 32'd1);
        wait_idle(tag);
        chk({tag, " one req"}, 128'(req_rises - r0), 128'd1);
        chk({tag, " wr_op"}, last_wr_op, !rd);
        if (!rd) chk({tag, " wdata"}, last_wdata, stage_vec());
        else rdbk_m = mst_mem;
        done_m = 1'b1;
    endtask

    task automatic check_rdbk(input string tag);
        for (int i = 0; i < 4; i++)
            bus_read(ADR_RDBK0 + 4'(i), rdbk_m[32*i +: 32], tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int r0;
        logic [31:0] w;
        model_reset();

        // Asynchronous reset from the start
        #3 reset_n = 1'b0;
        #1;
        chk("rst req", req, 1'b0);
        chk("rst busy", busy, 1'b0);
        chk("rst wr_op", wr_op, 1'b0);
        chk("rst rd_valid", bus_rd_valid, 1'b0);
        chk("rst rd_data", bus_rd_data, 32'd0);
        chk("rst wdata", coeff_wr_data, 128'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        bus_read(ADR_ID, 32'h0000F1C0, "id");
        bus_read(4'hA, 32'd0, "unmapped");
        bus_read(ADR_CTRL, 32'd0, "ctrl rd");
        bus_read(ADR_STATUS, status_exp(1'b0), "status rst");

        // Test 1: staged write op
        for (int i = 0; i < 4; i++) begin
            stage_m[i] = 32'(i + 1);
            bus_write(ADR_STAGE0 + 4'(i), stage_m[i]);
        end
        chk("stage vec", coeff_wr_data, 128'h00000004_00000003_00000002_00000001);
        run_op(1'b0, "wr op1");
        bus_read(ADR_STATUS, 32'h2, "status t1");
        bus_read(ADR_RDBK0, 32'd0, "rdbk after wr");

        // Test 2: read op with fixed pattern
        mst_mem = 128'hDDCCBBAA_99887766_55443322_11000011;
        run_op(1'b1, "rd op1");
        check_rdbk("rdbk t2");

        // Simultaneous read and write: write wins, read returns old data
        w = $urandom;
        bus_adr = ADR_STAGE0 + 4'd2; bus_wr_data = w; bus_wr = 1'b1; bus_rd = 1'b1;
        @(negedge clk);
        bus_wr = 1'b0; bus_rd = 1'b0;
        chk("rdwr old", bus_rd_data, stage_m[2]);
        stage_m[2] = w;
        bus_read(ADR_STAGE0 + 4'd2, stage_m[2], "rdwr new");

        // Randomised write/read ops
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 4; i++) begin
                stage_m[i] = $urandom;
                bus_write(ADR_STAGE0 + 4'(i), stage_m[i]);
            end
            rel_hold = $urandom_range(0, 2);
            run_op(1'b0, "rnd wr");
            mst_mem = {$urandom, $urandom, $urandom, $urandom};
            run_op(1'b1, "rnd rd");
            check_rdbk("rnd rdbk");
            bus_read(ADR_STAGE0 + 4'(k % 4), stage_m[k % 4], "rnd stage");
        end
        rel_hold = 0;

        // Test 3: errors
        mst_en = 1'b0;
        r0 = req_rises;
        bus_write(ADR_CTRL, 32'd1);
        done_m = 1'b0;
        bus_write(ADR_CTRL, 32'd1);
        err_m = 1'b1;
        bus_write(ADR_STAGE0 + 4'd1, 32'hDEADBEEF);
        bus_read(ADR_STATUS, status_exp(1'b1), "status busy err");
        bus_read(ADR_STAGE0 + 4'd1, stage_m[1], "stage locked");
        chk("err one req", 128'(req_rises - r0), 128'd1);
        mst_en = 1'b1;
        wait_idle("err op");
        done_m = 1'b1;
        chk("err op wdata", last_wdata, stage_vec());
        bus_read(ADR_STATUS, status_exp(1'b0), "status err done");
        bus_write(ADR_STATUS, 32'h4);
        err_m = 1'b0;
        bus_read(ADR_STATUS, status_exp(1'b0), "status w1c err");
        r0 = req_rises;
        bus_write(ADR_CTRL, 32'd3);
        err_m = 1'b1;
        chk("ctrl3 busy", busy, 1'b0);
        bus_write(ADR_CTRL, 32'd0);
        bus_read(ADR_STATUS, status_exp(1'b0), "status ctrl3");
        chk("ctrl3 no req", 128'(req_rises - r0), 128'd0);
        bus_write(ADR_STATUS, 32'h6);
        err_m = 1'b0; done_m = 1'b0;
        bus_read(ADR_STATUS, 32'h0, "status clear");

        // Test 4: ack held after req drops
        rel_hold = 5;
        mst_mem = {$urandom, $urandom, $urandom, $urandom};
        bus_write(ADR_CTRL, 32'd2);
        n = 0;
        while (req && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("hold req drop", req, 1'b0);
        chk("hold busy", busy, 1'b1);
        bus_read(ADR_STATUS, status_exp(1'b1), "status in rel");
        wait_idle("hold");
        rdbk_m = mst_mem; done_m = 1'b1;
        bus_read(ADR_STATUS, status_exp(1'b0), "status after rel");
        rel_hold = 0;
        run_op(1'b0, "b2b wr");
        mst_mem = {$urandom, $urandom, $urandom, $urandom};
        run_op(1'b1, "b2b rd");
        bus_read(ADR_STATUS, status_exp(1'b0), "status b2b");
        check_rdbk("rdbk b2b");

`ifdef FIR_COEFF_TIMEOUT_EN
        // Test 5: ack never arrives
        mst_en = 1'b0;
        bus_write(ADR_CTRL, 32'd1);
        done_m = 1'b0;
        n = 0;
        while (req && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("tmo req cycles", 128'(n), 128'(TB_TMO));
        wait_idle("tmo");
        tmo_m = 1'b1;
        bus_read(ADR_STATUS, 32'h8, "status tmo");
        mst_en = 1'b1;
        bus_write(ADR_STATUS, 32'h8);
        tmo_m = 1'b0;
        mst_mem = {$urandom, $urandom, $urandom, $urandom};
        run_op(1'b1, "after tmo");
        bus_read(ADR_STATUS, 32'h2, "status after tmo");
        check_rdbk("rdbk after tmo");
`endif

        // Test 6: asynchronous reset mid-REQ
        mst_en = 1'b0;
        bus_write(ADR_CTRL, 32'd1);
        chk("pre-rst req", req, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("async req", req, 1'b0);
        chk("async busy", busy, 1'b0);
        chk("async wdata", coeff_wr_data, 128'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        mst_en = 1'b1;
        @(negedge clk);
        bus_read(ADR_STAGE0, 32'd0, "post-rst stage");
        bus_read(ADR_RDBK0 + 4'd3, 32'd0, "post-rst rdbk");
        bus_read(ADR_STATUS, 32'd0, "post-rst status");

        chk("wr_op stable", 128'(wr_op_glitch), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
